// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage defaults and FSM state encoding
package fetch_pkg;
  localparam int FETCH_ADDR_W = 64;
  localparam int FETCH_INSTR_W = 32;
  localparam logic [63:0] FETCH_RESET_PC = 64'h0;
  localparam int FETCH_PC_INC = 4;
  localparam int FETCH_QDEPTH = 2;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_e;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small FIFO of {pc, instr} entries with flush overriding push/pop
module fetch_queue #(
  parameter int QDEPTH = 2,
  parameter int W = 96
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [$clog2(QDEPTH):0]  count,
  output logic [W-1:0]             head
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0] mem [QDEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  assign head = mem[rd_ptr];
  // storage and pointers; a flush empties the queue regardless of push/pop
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) mem[wr_ptr] <= din;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, memory fetch FSM and decode-facing instruction queue
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int INSTR_W = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC),
  parameter int PC_INC = FETCH_PC_INC,
  parameter int QDEPTH = FETCH_QDEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
);
  localparam int CW = $clog2(QDEPTH) + 1;
  fetch_state_e state;
  logic [ADDR_W-1:0] pc, pc_inc, redir_pc;
  logic [CW-1:0] count, count_nxt;
  logic push, pop;
  assign pc_inc = pc + ADDR_W'(PC_INC);
  assign redir_pc = redirect_pc & ~ADDR_W'(3);
  assign push = state == WAIT && mem_ack && !redirect_valid;
  assign pop = out_valid && out_ready && !redirect_valid;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign out_valid = count != '0;
  fetch_queue #(.QDEPTH(QDEPTH), .W(ADDR_W + INSTR_W)) u_queue (
    .clk(clk),
    .reset_n(reset_n),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .din({pc, mem_rdata}),
    .count(count),
    .head({out_pc, out_instr})
  );
  // fetch FSM: a redirect reloads pc and turns an unfinished request into a drop
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      mem_req <= 1'b0;
      mem_addr <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redir_pc;
      state <= (state != IDLE && !mem_ack) ? DROP : IDLE;
      mem_req <= state != IDLE && !mem_ack;
    end else if (state == IDLE) begin
      if (count < CW'(QDEPTH)) begin
        state <= WAIT;
        mem_req <= 1'b1;
        mem_addr <= pc;
      end
    end else if (mem_ack) begin
      if (state == WAIT) pc <= pc_inc;
      if (state == WAIT && count_nxt < CW'(QDEPTH)) mem_addr <= pc_inc;
      else begin
        state <= IDLE;
        mem_req <= 1'b0;
      end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table and sequence checks of the fetch stage
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset_n;
  logic mem_req, mem_ack, redirect_valid, out_valid, out_ready;
  logic [63:0] mem_addr, redirect_pc, out_pc;
  logic [31:0] mem_rdata, out_instr;
  logic mem_req_w, mem_ack_w, out_valid_w;
  logic [63:0] mem_addr_w, out_pc_w;
  logic [31:0] mem_rdata_w, out_instr_w;
  logic auto_ack;
  int lat;
  int wait_cnt;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic rdy;
    logic redir;
    logic [63:0] rpc;
    logic req;
    logic [63:0] addr;
    logic vld;
    logic [63:0] pc;
  } vec_t;
  vec_t tbl[17];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
    .clk(clk), .reset_n(reset_n), .mem_req(mem_req_w), .mem_addr(mem_addr_w),
    .mem_ack(mem_ack_w), .mem_rdata(mem_rdata_w), .redirect_valid(1'b0),
    .redirect_pc(64'h0), .out_valid(out_valid_w), .out_ready(1'b1),
    .out_instr(out_instr_w), .out_pc(out_pc_w)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // memory model for the main DUT: acks after lat idle cycles, data = ~addr
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    wait_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (auto_ack) begin
        mem_ack = 1'b0;
        if (mem_req && wait_cnt >= lat) begin
          mem_ack = 1'b1;
          mem_rdata = ~mem_addr[31:0];
          wait_cnt = 0;
        end else wait_cnt = mem_req ? wait_cnt + 1 : 0;
      end else wait_cnt = 0;
    end
  end

  // memory model for the wrap DUT: always acks one cycle after request
  initial begin
    mem_ack_w = 1'b0;
    mem_rdata_w = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack_w = mem_req_w;
      mem_rdata_w = ~mem_addr_w[31:0];
    end
  end

  initial begin
    logic [31:0] ei;
    reset_n = 1'b0;
    auto_ack = 1'b1;
    lat = 0;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    tbl[0]  = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h0,  1'b0, 64'h0};
    tbl[1]  = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h4,  1'b1, 64'h0};
    tbl[2]  = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h8,  1'b1, 64'h4};
    tbl[3]  = '{1'b1, 1'b0, 64'h0,  1'b1, 64'hC,  1'b1, 64'h8};
    tbl[4]  = '{1'b0, 1'b0, 64'h0,  1'b1, 64'h10, 1'b1, 64'hC};
    tbl[5]  = '{1'b0, 1'b0, 64'h0,  1'b0, 64'h10, 1'b1, 64'hC};
    tbl[6]  = '{1'b1, 1'b0, 64'h0,  1'b0, 64'h10, 1'b1, 64'hC};
    tbl[7]  = '{1'b0, 1'b0, 64'h0,  1'b0, 64'h10, 1'b1, 64'h10};
    tbl[8]  = '{1'b0, 1'b0, 64'h0,  1'b1, 64'h14, 1'b1, 64'h10};
    tbl[9]  = '{1'b1, 1'b0, 64'h0,  1'b0, 64'h14, 1'b1, 64'h10};
    tbl[10] = '{1'b1, 1'b0, 64'h0,  1'b0, 64'h14, 1'b1, 64'h14};
    tbl[11] = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h18, 1'b0, 64'h0};
    tbl[12] = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h1C, 1'b1, 64'h18};
    tbl[13] = '{1'b1, 1'b1, 64'h43, 1'b1, 64'h20, 1'b1, 64'h1C};
    tbl[14] = '{1'b1, 1'b0, 64'h0,  1'b0, 64'h20, 1'b0, 64'h0};
    tbl[15] = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h40, 1'b0, 64'h0};
    tbl[16] = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h44, 1'b1, 64'h40};

    repeat (2) @(negedge clk);
    chk("reset mem_req", mem_req, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_pc", out_pc, 0);
    chk("reset out_instr", out_instr, 0);
    reset_n = 1'b1;

    // streaming, backpressure, and redirect coinciding with an ack
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      chk($sformatf("row%0d mem_req", i + 1), mem_req, tbl[i].req);
      chk($sformatf("row%0d mem_addr", i + 1), mem_addr, tbl[i].addr);
      chk($sformatf("row%0d out_valid", i + 1), out_valid, tbl[i].vld);
      if (tbl[i].vld) begin
        ei = ~tbl[i].pc[31:0];
        chk($sformatf("row%0d out_pc", i + 1), out_pc, tbl[i].pc);
        chk($sformatf("row%0d out_instr", i + 1), out_instr, ei);
      end
      out_ready = tbl[i].rdy;
      redirect_valid = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
    end

    // redirect while a slow request is outstanding: stale data is dropped
    lat = 3;
    out_ready = 1'b1;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 64'h10;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("drop idle after redirect", mem_req, 0);
    @(negedge clk);
    chk("drop req 0x10", mem_req, 1);
    chk("drop addr 0x10", mem_addr, 64'h10);
    @(negedge clk);
    chk("drop addr held", mem_addr, 64'h10);
    redirect_valid = 1'b1;
    redirect_pc = 64'h103;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("drop req held", mem_req, 1);
    chk("drop addr held 2", mem_addr, 64'h10);
    chk("drop valid", out_valid, 0);
    @(negedge clk);
    chk("drop addr held 3", mem_addr, 64'h10);
    @(negedge clk);
    chk("drop back to idle", mem_req, 0);
    chk("drop no entry", out_valid, 0);
    @(negedge clk);
    chk("drop new req", mem_req, 1);
    chk("drop new addr", mem_addr, 64'h100);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("drop wait%0d valid", k), out_valid, 0);
      chk($sformatf("drop wait%0d addr", k), mem_addr, 64'h100);
    end
    @(negedge clk);
    chk("drop new valid", out_valid, 1);
    chk("drop new pc", out_pc, 64'h100);
    chk("drop new instr", out_instr, 64'h0000_0000_FFFF_FEFF);

    // address wrap on the second instance
    lat = 0;
    do_reset();
    @(negedge clk);
    chk("wrap req", mem_req_w, 1);
    chk("wrap addr0", mem_addr_w, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);
    chk("wrap addr1", mem_addr_w, 64'h0);
    chk("wrap head pc", out_pc_w, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap head instr", out_instr_w, 64'h3);
    @(negedge clk);
    chk("wrap addr2", mem_addr_w, 64'h4);
    chk("wrap head pc2", out_pc_w, 64'h0);

    // reset mid-request, then a late ack while idle
    out_ready = 1'b0;
    do_reset();
    @(negedge clk);
    chk("rst seq req", mem_req, 1);
    @(negedge clk);
    chk("rst seq valid pre", out_valid, 1);
    chk("rst seq addr pre", mem_addr, 64'h4);
    auto_ack = 1'b0;
    mem_ack = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("async rst mem_req", mem_req, 0);
    chk("async rst out_valid", out_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    auto_ack = 1'b1;
    chk("late ack ignored", out_valid, 0);
    chk("restart req", mem_req, 1);
    chk("restart addr", mem_addr, 64'h0);
    @(negedge clk);
    chk("restart waiting", out_valid, 0);
    @(negedge clk);
    chk("restart valid", out_valid, 1);
    chk("restart pc", out_pc, 64'h0);
    chk("restart instr", out_instr, 64'h0000_0000_FFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
